// File: rtl/crc32_rx_send.sv
// crc32_rx_send: receive back-end for the MII Ethernet receiver.
// Two independent functions on one clock/reset:
//   - byte-wide Ethernet CRC-32 engine (FCS residue checking)
//   - packet-to-byte-stream sender over a valid/ready byte interface
// Ports:
//   rx_clk, rst          clock, synchronous active-high reset
//   crc_en, data_in      CRC byte strobe and byte
//   sof, eof             restart / freeze the CRC
//   crc_out, crc_done    CRC register, one-cycle pulse after eof
//   rx_pkt_vld/rdy       packet offer handshake
//   rx_pkt, rx_pkt_bytes payload buffer (byte i at [8i+7:8i]) and byte count
//   tx_byte_vld/rdy      output byte handshake
//   tx_byte              output byte
module crc32_rx_send #(
  parameter int P_PKT_BITS = 12000
) (
  input  logic                  rx_clk,
  input  logic                  rst,
  input  logic                  crc_en,
  input  logic [7:0]            data_in,
  input  logic                  sof,
  input  logic                  eof,
  output logic [31:0]           crc_out,
  output logic                  crc_done,
  input  logic                  rx_pkt_vld,
  output logic                  rx_pkt_rdy,
  input  logic [P_PKT_BITS-1:0] rx_pkt,
  input  logic [10:0]           rx_pkt_bytes,
  output logic                  tx_byte_vld,
  input  logic                  tx_byte_rdy,
  output logic [7:0]            tx_byte
);

  localparam int          MAX_BYTES = P_PKT_BITS / 8;
  localparam logic [31:0] CRC_POLY  = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT  = 32'hFFFFFFFF;

  // Left-shifting register, data bits fed LSB first.
  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++)
      r = {r[30:0], 1'b0} ^ ((r[31] ^ d[i]) ? CRC_POLY : 32'h0);
    return r;
  endfunction

  // ---------------- CRC engine ----------------
  typedef enum logic {CRC_ACTIVE, CRC_FROZEN} crc_state_t;

  crc_state_t  crc_st, crc_st_nxt;
  logic [31:0] crc_nxt;
  logic        done_nxt;

  always_ff @(posedge rx_clk) begin
    if (rst) begin
      crc_st   <= CRC_ACTIVE;
      crc_out  <= CRC_INIT;
      crc_done <= 1'b0;
    end else begin
      crc_st   <= crc_st_nxt;
      crc_out  <= crc_nxt;
      crc_done <= done_nxt;
    end
  end

  always_comb begin
    crc_st_nxt = crc_st;
    crc_nxt    = crc_out;
    done_nxt   = eof;
    if (eof) begin
      // eof wins over everything, including a coincident sof
      crc_st_nxt = CRC_FROZEN;
    end else if (sof) begin
      crc_st_nxt = CRC_ACTIVE;
      crc_nxt    = crc_en ? crc_step(CRC_INIT, data_in) : CRC_INIT;
    end else if (crc_en && crc_st == CRC_ACTIVE) begin
      crc_nxt = crc_step(crc_out, data_in);
    end
  end

  // ---------------- Packet sender ----------------
  typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;

  tx_state_t             tx_st, tx_st_nxt;
  logic [10:0]           idx, idx_nxt, cnt, cnt_nxt, cnt_clip;
  logic                  cap;
  logic [P_PKT_BITS-1:0] pkt_buf;

  assign cnt_clip = (rx_pkt_bytes > 11'(MAX_BYTES)) ? 11'(MAX_BYTES) : rx_pkt_bytes;

  always_comb begin
    tx_st_nxt = tx_st;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    cap       = 1'b0;
    case (tx_st)
      TX_IDLE: begin
        if (rx_pkt_vld) begin
          cap     = 1'b1;
          cnt_nxt = cnt_clip;
          idx_nxt = 11'd0;
          if (cnt_clip != 11'd0) tx_st_nxt = TX_SEND;
        end
      end
      TX_SEND: begin
        if (tx_byte_rdy) begin
          if (idx + 11'd1 == cnt) begin
            tx_st_nxt = TX_IDLE;
            idx_nxt   = 11'd0;
          end else begin
            idx_nxt = idx + 11'd1;
          end
        end
      end
      default: tx_st_nxt = TX_IDLE;
    endcase
  end

  always_ff @(posedge rx_clk) begin
    if (rst) begin
      tx_st <= TX_IDLE;
      idx   <= 11'd0;
      cnt   <= 11'd0;
    end else begin
      tx_st <= tx_st_nxt;
      idx   <= idx_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Payload storage needs no reset; it is only read while in SEND.
  always_ff @(posedge rx_clk) begin
    if (!rst && cap) pkt_buf <= rx_pkt;
  end

  // rdy is forced high during reset so the offer side sees the block as free.
  assign rx_pkt_rdy  = (tx_st == TX_IDLE) || rst;
  assign tx_byte_vld = (tx_st == TX_SEND);
  assign tx_byte     = tx_byte_vld ? pkt_buf[{idx, 3'b000} +: 8] : 8'h00;

endmodule

// File: tb/tb_crc32_rx_send.sv
module tb_crc32_rx_send;
  localparam int PB = 12000;

  logic          rx_clk = 1'b0;
  logic          rst = 1'b1;
  logic          crc_en = 1'b0, sof = 1'b0, eof = 1'b0;
  logic [7:0]    data_in = 8'h00;
  logic [31:0]   crc_out;
  logic          crc_done;
  logic          rx_pkt_vld = 1'b0, rx_pkt_rdy;
  logic [PB-1:0] rx_pkt = '0;
  logic [10:0]   rx_pkt_bytes = 11'd0;
  logic          tx_byte_vld, tx_byte_rdy = 1'b0;
  logic [7:0]    tx_byte;

  crc32_rx_send #(.P_PKT_BITS(PB)) dut (
    .rx_clk(rx_clk), .rst(rst), .crc_en(crc_en), .data_in(data_in), .sof(sof), .eof(eof),
    .crc_out(crc_out), .crc_done(crc_done), .rx_pkt_vld(rx_pkt_vld), .rx_pkt_rdy(rx_pkt_rdy),
    .rx_pkt(rx_pkt), .rx_pkt_bytes(rx_pkt_bytes), .tx_byte_vld(tx_byte_vld),
    .tx_byte_rdy(tx_byte_rdy), .tx_byte(tx_byte));

  always #5 rx_clk = ~rx_clk;

  int n_chk = 0, n_fail = 0;

  // reference CRC state, kept in the reported (non-reflected) form
  logic [31:0] m_crc;
  bit          m_frozen, m_done;
  logic [7:0]  exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge rx_clk);
    #1;
  endtask

  function automatic logic [31:0] rev32(input logic [31:0] x);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = x[31-i];
    return r;
  endfunction

  // textbook reflected Ethernet CRC byte update (poly 0xEDB88320)
  function automatic logic [31:0] refl_step(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  // LSB-first feed into a left-shifting register = bit-reversed reflected CRC
  function automatic logic [31:0] ref_step(input logic [31:0] c, input logic [7:0] d);
    return rev32(refl_step(rev32(c), d));
  endfunction

  task automatic do_reset();
    rst = 1'b1; crc_en = 0; sof = 0; eof = 0; data_in = 0;
    rx_pkt_vld = 0; tx_byte_rdy = 0;
    tick();
    chk("rst_rdy_during", rx_pkt_rdy, 1);
    rst = 1'b0;
    m_crc = 32'hFFFFFFFF; m_frozen = 0; m_done = 0;
    exp_q.delete();
    #1;
    chk("rst_crc", crc_out, 32'hFFFFFFFF);
    chk("rst_done", crc_done, 0);
    chk("rst_tx_vld", tx_byte_vld, 0);
    chk("rst_tx_byte", tx_byte, 0);
    chk("rst_pkt_rdy", rx_pkt_rdy, 1);
  endtask

  task automatic crc_cycle(input bit s, input bit en, input bit e, input logic [7:0] d);
    sof = s; crc_en = en; eof = e; data_in = d;
    tick();
    m_done = e;
    if (e) m_frozen = 1;
    else if (s) begin
      m_crc = en ? ref_step(32'hFFFFFFFF, d) : 32'hFFFFFFFF;
      m_frozen = 0;
    end else if (en && !m_frozen) m_crc = ref_step(m_crc, d);
    chk("crc_out", crc_out, m_crc);
    chk("crc_done", crc_done, m_done);
    sof = 0; crc_en = 0; eof = 0;
  endtask

  task automatic feed_frame(input logic [7:0] q[$], input bit alt);
    if (alt) crc_cycle(1, 0, 0, 8'($urandom));
    for (int i = 0; i < q.size(); i++) begin
      crc_cycle(!alt && i == 0, 1, 0, q[i]);
      if (alt) crc_cycle(0, 0, 0, 8'($urandom));
    end
    crc_cycle(0, 0, 1, 8'($urandom));
  endtask

  task automatic pkt_pulse(input int nbytes);
    chk("pkt_rdy_idle", rx_pkt_rdy, 1);
    rx_pkt_bytes = 11'(nbytes);
    rx_pkt_vld = 1'b1;
    tick();
    rx_pkt_vld = 1'b0;
    for (int i = 0; i < ((nbytes > 1500) ? 1500 : nbytes); i++) exp_q.push_back(rx_pkt[8*i +: 8]);
  endtask

  // mode 0: rdy always high, 1: three low cycles mid-packet, 2: random rdy
  task automatic drain(input int mode, input bit inject);
    int cyc = 0;
    int n = exp_q.size();
    bit r;
    while (exp_q.size() > 0 && cyc < n * 4 + 50) begin
      chk("tx_vld", tx_byte_vld, 1);
      chk("tx_byte", tx_byte, exp_q[0]);
      chk("pkt_rdy_send", rx_pkt_rdy, 0);
      case (mode)
        0: r = 1;
        1: r = !(cyc >= 2 && cyc <= 4);
        default: r = ($urandom % 3) != 0;
      endcase
      tx_byte_rdy = r;
      if (inject && cyc == 3) begin
        rx_pkt = ~rx_pkt; rx_pkt_bytes = 11'd7; rx_pkt_vld = 1'b1;
      end
      tick();
      rx_pkt_vld = 1'b0;
      if (r) void'(exp_q.pop_front());
      cyc++;
    end
    chk("drain_done", exp_q.size(), 0);
    if (mode == 0) chk("drain_cycles", cyc, n);
    chk("end_tx_vld", tx_byte_vld, 0);
    chk("end_pkt_rdy", rx_pkt_rdy, 1);
  endtask

  initial begin
    logic [7:0] q[$];
    logic [31:0] fcs;
    int n;

    do_reset();

    // "123456789" known vector
    q.delete();
    for (int i = 0; i < 9; i++) q.push_back(8'h31 + 8'(i));
    feed_frame(q, 0);
    chk("check_val", crc_out, 32'h9B63D02C);
    chk("done_pulse", crc_done, 1);
    crc_cycle(0, 0, 0, 8'h00);
    chk("done_one_cycle", crc_done, 0);

    // residue with FCS
    q.push_back(8'h26); q.push_back(8'h39); q.push_back(8'hF4); q.push_back(8'hCB);
    feed_frame(q, 0);
    chk("residue", crc_out, 32'hC704DD7B);

    // corrupted payload bit
    q[4] = q[4] ^ 8'h01;
    feed_frame(q, 0);
    chk("corrupt_ne", (crc_out != 32'hC704DD7B), 1);
    q[4] = q[4] ^ 8'h01;

    // alternate-cycle strobes, sof in a crc_en=0 cycle
    feed_frame(q, 1);
    chk("alt_residue", crc_out, 32'hC704DD7B);
    for (int i = 0; i < 6; i++) crc_cycle(0, i % 2, 0, 8'($urandom));
    chk("frozen_hold", crc_out, 32'hC704DD7B);
    crc_cycle(0, 1, 1, 8'($urandom));
    chk("re_eof_done", crc_done, 1);
    chk("re_eof_val", crc_out, 32'hC704DD7B);
    crc_cycle(0, 0, 0, 8'h00);

    // random good frames: FCS from the reflected model, residue must match
    for (int f = 0; f < 4; f++) begin
      q.delete();
      n = $urandom_range(1, 30);
      fcs = 32'hFFFFFFFF;
      for (int i = 0; i < n; i++) begin
        q.push_back(8'($urandom));
        fcs = refl_step(fcs, q[i]);
      end
      fcs = ~fcs;
      for (int b = 0; b < 4; b++) q.push_back(fcs[8*b +: 8]);
      feed_frame(q, f[0]);
      chk("rand_residue", crc_out, 32'hC704DD7B);
    end

    // random control mix
    for (int i = 0; i < 300; i++)
      crc_cycle(($urandom % 10) == 0, $urandom % 2, ($urandom % 12) == 0, 8'($urandom));

    // sender basic
    rx_pkt = '0;
    for (int i = 0; i < 5; i++) rx_pkt[8*i +: 8] = 8'hA0 + 8'(i);
    pkt_pulse(5);
    drain(0, 0);

    // backpressure plus ignored offer during SEND
    for (int i = 0; i < 12; i++) rx_pkt[8*i +: 8] = 8'($urandom);
    pkt_pulse(12);
    drain(1, 1);

    // zero-length packet
    pkt_pulse(0);
    for (int i = 0; i < 3; i++) begin
      chk("zero_vld", tx_byte_vld, 0);
      chk("zero_rdy", rx_pkt_rdy, 1);
      tick();
    end

    // oversize count clips to capacity
    for (int i = 0; i < PB / 32; i++) rx_pkt[32*i +: 32] = $urandom;
    tx_byte_rdy = 1'b1;
    pkt_pulse(2000);
    drain(2, 0);

    // reset mid-send
    for (int i = 0; i < 10; i++) rx_pkt[8*i +: 8] = 8'($urandom);
    pkt_pulse(10);
    tx_byte_rdy = 1'b1;
    tick(); tick(); tick();
    do_reset();
    tick();
    chk("post_rst_vld", tx_byte_vld, 0);
    chk("post_rst_rdy", rx_pkt_rdy, 1);
    for (int i = 0; i < 8; i++) rx_pkt[8*i +: 8] = 8'($urandom);
    pkt_pulse(8);
    drain(0, 0);

    // random packets, random backpressure
    for (int p = 0; p < 5; p++) begin
      n = $urandom_range(1, 40);
      for (int i = 0; i < n; i++) rx_pkt[8*i +: 8] = 8'($urandom);
      pkt_pulse(n);
      drain(2, p[0]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/crc32_rx_send.md
Name: crc32_rx_send

Overview:
- Receive back-end for the MII Ethernet receiver.
- Contains two independent functions that share one clock and reset:
  - a byte-wide Ethernet CRC-32 engine, used for FCS residue checking;
  - a packet-to-byte-stream sender that serialises a received payload buffer over a valid/ready byte interface.
- Sits between the MII receive state machine and the downstream byte consumer.

Parameters:
- P_PKT_BITS, 12000, payload buffer width in bits; capacity P_PKT_BITS/8 = 1500 bytes.

Ports:
- rx_clk  in  1  sole clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- crc_en  in  1  byte strobe; data_in is consumed on cycles where crc_en=1.
- data_in  in  8  CRC input byte.
- sof  in  1  start of frame; restarts the CRC.
- eof  in  1  end of frame; freezes the CRC.
- crc_out  out  32  CRC register.
- crc_done  out  1  one-cycle pulse after eof.
- rx_pkt_vld  in  1  packet offer.
- rx_pkt_rdy  out  1  sender can accept a packet.
- rx_pkt  in  P_PKT_BITS  payload; byte i is at bits [8i+7:8i].
- rx_pkt_bytes  in  11  payload byte count.
- tx_byte_vld  out  1  output byte valid.
- tx_byte_rdy  in  1  downstream accepts the byte.
- tx_byte  out  8  output byte.

Behaviour:
Reset (rst=1 at a clock edge):
- crc_out=32'hFFFFFFFF, crc_done=0, CRC state ACTIVE.
- Sender state IDLE: tx_byte_vld=0, tx_byte=0, index=0.
- All inputs are ignored while rst=1.
- Reset mid-frame or mid-send aborts immediately; no further bytes are emitted.

CRC algorithm:
- Polynomial 0x04C11DB7, normal (non-reflected) register, shifted left.
- Bits of each byte are processed LSB first (data_in[0] first).
- Init value 0xFFFFFFFF; no final inversion; crc_out is the register itself.
- A good frame (header + payload + FCS) leaves crc_out = 32'hC704DD7B.

CRC per-cycle priority:
1. eof=1: register holds and the data byte is ignored; state goes to FROZEN; crc_done=1 on the next cycle, for exactly one cycle.
2. sof=1 and crc_en=1: register = step(0xFFFFFFFF, data_in); state ACTIVE.
3. sof=1 and crc_en=0: register = 0xFFFFFFFF; state ACTIVE.
4. crc_en=1 in ACTIVE: register = step(register, data_in).
5. Otherwise, or in FROZEN: hold.

CRC rules:
- crc_out stays stable after eof until the next sof.
- A repeated eof while FROZEN produces another crc_done pulse; the value is unchanged.
- The 8-bit step is combinational within one cycle: one byte per enabled cycle, so back-to-back crc_en is allowed.

Sender states:
- IDLE: rx_pkt_rdy=1 (combinational from state; also 1 during and right after reset).
  - On rx_pkt_vld=1: capture rx_pkt into an internal buffer and count = min(rx_pkt_bytes, P_PKT_BITS/8).
  - If count=0: stay IDLE.
  - Otherwise: go to SEND with index=0.
  - A single-cycle vld pulse must be accepted.
- SEND: rx_pkt_rdy=0; tx_byte_vld=1; tx_byte = buffer byte[index].
  - tx_byte stays stable while tx_byte_rdy=0.
  - On tx_byte_rdy=1: index+1. After byte count-1 is accepted, go to IDLE with tx_byte_vld=0 on the next cycle.
  - rx_pkt_vld is ignored in SEND; a later packet does not corrupt the buffer.

Sender timing:
- Accept edge k: byte 0 is valid in cycle k+1.
- With tx_byte_rdy held high, bytes appear on consecutive cycles; N bytes take N cycles.
- rx_pkt_rdy returns to 1 in the cycle after the last handshake.

Independence:
- The CRC and sender functions do not interact; simultaneous activity on both is legal.

Test Plan:
- CRC known vector: sof+crc_en with 0x31, then crc_en for 0x32..0x39 ("123456789"), then eof → crc_out=0x9B63D02C; crc_done=1 for exactly one cycle, one cycle after eof.
- Residue: same stream followed by FCS bytes 0x26,0x39,0xF4,0xCB, then eof → crc_out=0xC704DD7B. Corrupt one payload bit → crc_out≠0xC704DD7B.
- Strobe/freeze: bytes on alternate cycles (crc_en toggling, sof also high in the preceding crc_en=0 cycle) → same results as above. Toggling crc_en with junk data after eof → crc_out unchanged until the next sof.
- Sender basic: rx_pkt bytes 0..4 = 0xA0..0xA4, rx_pkt_bytes=5, one-cycle vld pulse, tx_byte_rdy=1 → tx_byte 0xA0..0xA4 on 5 consecutive cycles starting the cycle after the pulse; rdy low for exactly 5 cycles.
- Backpressure: tx_byte_rdy low for 3 cycles mid-packet → byte held stable and vld held high; no byte lost or duplicated. A vld pulse during SEND is ignored.
- Edges: rx_pkt_bytes=0 → no output and rdy stays 1. rx_pkt_bytes=2000 → exactly 1500 bytes sent. rst asserted mid-send → tx_byte_vld=0 and rdy=1 the next cycle; a fresh packet then sends correctly.
